// File: rtl/glitchcore_wb_host_if.sv
// Bundle of the host byte streams and the Wishbone classic initiator bus.
// Latency: none, wires only.
// Backpressure: valid/ready on both byte streams, ack-terminated cycles on Wishbone.
interface glitchcore_wb_host_if;
    // Command byte stream from the host
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    // Response byte stream back to the host
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;

    // Wishbone classic initiator side
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic        wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    // The bridge drives the bus and consumes commands
    modport master (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready,
        output rsp_data,
        output rsp_valid,
        input  rsp_ready,
        output wb_adr_o,
        output wb_dat_o,
        input  wb_dat_i,
        output wb_we_o,
        output wb_sel_o,
        output wb_stb_o,
        output wb_cyc_o,
        input  wb_ack_i
    );

    // Host plus Wishbone target seen from the outside
    modport slave (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready,
        input  rsp_data,
        input  rsp_valid,
        output rsp_ready,
        input  wb_adr_o,
        input  wb_dat_o,
        output wb_dat_i,
        input  wb_we_o,
        input  wb_sel_o,
        input  wb_stb_o,
        input  wb_cyc_o,
        output wb_ack_i
    );
endinterface

// File: rtl/glitchcore_wb_host.sv
// Byte-command to Wishbone classic bridge: 'W' adr d3 d2 d1 d0 / 'R' adr, answers status (+ read data).
// Latency: bus cycle issued the edge after the last command byte; first response byte one edge after ack/timeout.
// Backpressure: cmd_ready low while a bus cycle or response is in flight; response bytes held while rsp_ready is low.
module glitchcore_wb_host #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    glitchcore_wb_host_if.master link
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] OP_READ    = 8'h52;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;
    localparam logic [7:0] ST_BADOP   = 8'hFF;

    // Wait counter value at which the cycle is abandoned: the counter would
    // reach TIMEOUT on this edge, giving exactly TIMEOUT cycles of strobe.
    localparam logic [7:0] WAIT_TERM = 8'(TIMEOUT - 1);

    logic [2:0]  state;
    logic        is_write;
    logic        is_read;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  byte_cnt;
    logic [7:0]  wait_cnt;
    logic [7:0]  status;
    logic [31:0] rdata;
    logic [2:0]  rsp_idx;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_sel;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;

    logic        cmd_ready;
    logic        cmd_fire;
    logic        rsp_valid;
    logic        rsp_fire;
    logic        rsp_last;
    logic [7:0]  rsp_byte;

    // Stream handshakes; cmd_ready is forced low while reset is held
    always_comb begin
        cmd_ready = rst && ((state == S_IDLE) || (state == S_ADDR) || (state == S_DATA));
        cmd_fire  = link.cmd_valid && cmd_ready;
        rsp_valid = (state == S_RESP);
        rsp_fire  = rsp_valid && link.rsp_ready;
        rsp_last  = is_read ? (rsp_idx == 3'd4) : (rsp_idx == 3'd0);
    end

    // Response byte select: status first, then read data MSB first
    always_comb begin
        rsp_byte = 8'h00;
        if (state == S_RESP) begin
            case (rsp_idx)
                3'd0:    rsp_byte = status;
                3'd1:    rsp_byte = rdata[31:24];
                3'd2:    rsp_byte = rdata[23:16];
                3'd3:    rsp_byte = rdata[15:8];
                3'd4:    rsp_byte = rdata[7:0];
                default: rsp_byte = 8'h00;
            endcase
        end
    end

    assign link.cmd_ready = cmd_ready;
    assign link.rsp_valid = rsp_valid;
    assign link.rsp_data  = rsp_byte;
    assign link.wb_cyc_o  = wb_cyc;
    assign link.wb_stb_o  = wb_stb;
    assign link.wb_sel_o  = wb_sel;
    assign link.wb_we_o   = wb_we;
    assign link.wb_adr_o  = wb_adr;
    assign link.wb_dat_o  = wb_dat;

    // Command parser, bus cycle control and response sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            is_write <= 1'b0;
            is_read  <= 1'b0;
            addr     <= 8'h00;
            wdata    <= 32'h0;
            byte_cnt <= 2'd0;
            wait_cnt <= 8'h00;
            status   <= 8'h00;
            rdata    <= 32'h0;
            rsp_idx  <= 3'd0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_sel   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= 32'h0;
            wb_dat   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        is_write <= (link.cmd_data == OP_WRITE);
                        is_read  <= (link.cmd_data == OP_READ);
                        if ((link.cmd_data == OP_WRITE) || (link.cmd_data == OP_READ)) begin
                            state <= S_ADDR;
                        end else begin
                            // Unknown opcode: single error byte, no bus activity
                            status  <= ST_BADOP;
                            rsp_idx <= 3'd0;
                            state   <= S_RESP;
                        end
                    end
                end

                S_ADDR: begin
                    if (cmd_fire) begin
                        addr <= link.cmd_data;
                        if (is_write) begin
                            byte_cnt <= 2'd0;
                            state    <= S_DATA;
                        end else begin
                            // Read goes straight onto the bus with the fresh address
                            wait_cnt <= 8'h00;
                            wb_cyc   <= 1'b1;
                            wb_stb   <= 1'b1;
                            wb_sel   <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_adr   <= {24'h0, link.cmd_data};
                            wb_dat   <= wdata;
                            state    <= S_BUS;
                        end
                    end
                end

                S_DATA: begin
                    if (cmd_fire) begin
                        wdata    <= {wdata[23:0], link.cmd_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wait_cnt <= 8'h00;
                            wb_cyc   <= 1'b1;
                            wb_stb   <= 1'b1;
                            wb_sel   <= 1'b1;
                            wb_we    <= 1'b1;
                            wb_adr   <= {24'h0, addr};
                            wb_dat   <= {wdata[23:0], link.cmd_data};
                            state    <= S_BUS;
                        end
                    end
                end

                S_BUS: begin
                    // Ack is checked first so it wins over a simultaneous terminal count
                    if (link.wb_ack_i || (wait_cnt == WAIT_TERM)) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        wb_sel  <= 1'b0;
                        wb_we   <= 1'b0;
                        wb_adr  <= 32'h0;
                        wb_dat  <= 32'h0;
                        rsp_idx <= 3'd0;
                        state   <= S_RESP;
                        if (link.wb_ack_i) begin
                            status <= ST_OK;
                            if (is_read) begin
                                rdata <= link.wb_dat_i;
                            end
                        end else begin
                            status <= ST_TIMEOUT;
                            rdata  <= 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_RESP: begin
                    if (rsp_fire) begin
                        if (rsp_last) begin
                            state <= S_IDLE;
                        end else begin
                            rsp_idx <= rsp_idx + 3'd1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitchcore_wb_host.sv
// Self-checking bench for glitchcore_wb_host: directed cases then randomized transactions.
// Expected responses come from a transaction-level model of the command protocol.
// A behavioural Wishbone target acks after a programmable delay and records what it saw.
module tb_glitchcore_wb_host;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    glitchcore_wb_host_if link();

    glitchcore_wb_host #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    int          ack_delay   = 0;
    logic [31:0] slave_rdata = 32'h0;
    logic        stray_ack   = 1'b0;

    int          stb_total    = 0;
    int          stb_run      = 0;
    int          unstable_cnt = 0;
    logic [31:0] cap_adr      = 32'h0;
    logic [31:0] cap_dat      = 32'h0;
    logic        cap_we       = 1'b0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    // Wishbone target: acks once its strobe count reaches ack_delay, checks hold-stability
    initial begin
        link.wb_ack_i = 1'b0;
        link.wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            link.wb_dat_i = slave_rdata;
            if (link.wb_stb_o) begin
                if (stb_run == 0) begin
                    cap_adr = link.wb_adr_o;
                    cap_dat = link.wb_dat_o;
                    cap_we  = link.wb_we_o;
                end else if (link.wb_adr_o !== cap_adr || link.wb_dat_o !== cap_dat ||
                             link.wb_we_o !== cap_we || link.wb_cyc_o !== 1'b1 ||
                             link.wb_sel_o !== 1'b1) begin
                    unstable_cnt++;
                end
                link.wb_ack_i = (stb_run == ack_delay);
                stb_run++;
                stb_total++;
            end else begin
                link.wb_ack_i = stray_ack;
                stb_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Protocol-level model: what the host should read back for one command
    task automatic model(input logic [7:0] op, input int delay, input logic [31:0] rd);
        logic [7:0] st;
        exp_q.delete();
        if (op == 8'h57 || op == 8'h52) begin
            st = (delay < TO) ? 8'h00 : 8'hEE;
            exp_q.push_back(st);
            if (op == 8'h52) begin
                for (int i = 3; i >= 0; i--) begin
                    exp_q.push_back((st == 8'h00) ? rd[8*i +: 8] : 8'h00);
                end
            end
        end else begin
            exp_q.push_back(8'hFF);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        link.cmd_data  = b;
        link.cmd_valid = 1'b1;
        @(negedge clk);
        while (!link.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!link.cmd_ready) check("cmd_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready dropped for 3 cycles after the first byte
    task automatic collect(input int n, input int mode);
        int         c;
        logic       holding;
        logic [7:0] held;
        got_q.delete();
        holding = 1'b0;
        held    = 8'h00;
        c       = 0;
        while (got_q.size() < n && c < 300) begin
            case (mode)
                0:       link.rsp_ready = 1'b1;
                1:       link.rsp_ready = 1'($urandom_range(0, 1));
                default: link.rsp_ready = !(c >= 1 && c <= 3);
            endcase
            @(negedge clk);
            if (holding) begin
                check("rsp_hold_valid", 32'(link.rsp_valid), 32'd1);
                check("rsp_hold_data", 32'(link.rsp_data), 32'(held));
            end
            holding = link.rsp_valid && !link.rsp_ready;
            held    = link.rsp_data;
            if (link.rsp_valid && link.rsp_ready) got_q.push_back(link.rsp_data);
            @(posedge clk);
            #1;
            c++;
        end
        link.rsp_ready = 1'b0;
        if (got_q.size() < n) check("rsp_wait", 32'd0, 32'd1);
    endtask

    task automatic do_txn(input logic [7:0] op, input logic [7:0] a, input logic [31:0] wd,
                          input int delay, input logic [31:0] rd, input int mode, input bit lat);
        int base_stb;
        int base_uns;
        int exp_stb;
        bit is_w;
        bit is_r;
        is_w = (op == 8'h57);
        is_r = (op == 8'h52);
        model(op, delay, rd);
        ack_delay   = delay;
        slave_rdata = rd;
        base_stb    = stb_total;
        base_uns    = unstable_cnt;
        send_byte(op);
        if (is_w || is_r) send_byte(a);
        if (is_w) begin
            for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8]);
        end
        link.cmd_valid = 1'b0;
        if (lat) begin
            @(negedge clk);
            check("lat_cycle1_rsp_valid", 32'(link.rsp_valid), 32'd0);
            check("lat_cycle1_stb", 32'(link.wb_stb_o), 32'd1);
            @(negedge clk);
            check("lat_cycle2_rsp_valid", 32'(link.rsp_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        collect(exp_q.size(), mode);
        check("rsp_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check("rsp_byte", 32'(got_q[i]), 32'(exp_q[i]));
        end
        @(negedge clk);
        check("rsp_valid_after_last", 32'(link.rsp_valid), 32'd0);
        check("cmd_ready_after_last", 32'(link.cmd_ready), 32'd1);
        exp_stb = (is_w || is_r) ? ((delay < TO) ? delay + 1 : TO) : 0;
        check("stb_cycles", 32'(stb_total - base_stb), 32'(exp_stb));
        check("wb_stable", 32'(unstable_cnt - base_uns), 32'd0);
        if (is_w || is_r) begin
            check("wb_adr", cap_adr, {24'h0, a});
            check("wb_we", 32'(cap_we), 32'(is_w));
            if (is_w) check("wb_dat", cap_dat, wd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       ok;
        logic [7:0] op;
        int         r;

        rst            = 1'b0;
        link.cmd_data  = 8'h00;
        link.cmd_valid = 1'b0;
        link.rsp_ready = 1'b0;

        // Outputs while reset is held
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(link.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(link.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(link.rsp_data), 32'd0);
        check("rst_cyc", 32'(link.wb_cyc_o), 32'd0);
        check("rst_stb", 32'(link.wb_stb_o), 32'd0);
        check("rst_we", 32'(link.wb_we_o), 32'd0);
        check("rst_sel", 32'(link.wb_sel_o), 32'd0);
        check("rst_adr", link.wb_adr_o, 32'd0);
        check("rst_dat", link.wb_dat_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(link.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic write and read with immediate ack, including first-response latency
        do_txn(8'h57, 8'h14, 32'h0000_0008, 0, 32'h0, 0, 1'b1);
        do_txn(8'h52, 8'h24, 32'h0, 0, 32'h0000_0010, 0, 1'b1);

        // Timeouts: write, then read whose data must read back as zero
        do_txn(8'h57, 8'h30, 32'hA5A5_5A5A, 255, 32'h0, 0, 1'b0);
        do_txn(8'h52, 8'h40, 32'h0, 255, 32'hDEAD_BEEF, 1, 1'b0);

        // Ack on the same edge as the terminal count must win
        do_txn(8'h52, 8'h41, 32'h0, TO - 1, 32'h1234_5678, 0, 1'b0);
        do_txn(8'h57, 8'h42, 32'h0BAD_F00D, TO - 1, 32'h0, 0, 1'b0);

        // Bad opcode, then a normal command
        do_txn(8'h41, 8'h00, 32'h0, 0, 32'h0, 0, 1'b0);
        do_txn(8'h57, 8'h50, 32'h1122_3344, 1, 32'h0, 0, 1'b0);

        // Response backpressure on a read
        do_txn(8'h52, 8'h55, 32'h0, 0, 32'hCAFE_F00D, 2, 1'b1);

        // Ack outside a bus cycle is ignored
        stray_ack = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (link.wb_cyc_o || link.wb_stb_o || link.rsp_valid || !link.cmd_ready) ok = 1'b0;
        end
        stray_ack = 1'b0;
        check("stray_ack_ignored", 32'(ok), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a bus cycle
        ack_delay = 255;
        send_byte(8'h57);
        send_byte(8'h60);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        link.cmd_valid = 1'b0;
        @(negedge clk);
        check("midbus_stb_before_rst", 32'(link.wb_stb_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midbus_cyc_async", 32'(link.wb_cyc_o), 32'd0);
        check("midbus_stb_async", 32'(link.wb_stb_o), 32'd0);
        check("midbus_rsp_valid", 32'(link.rsp_valid), 32'd0);
        check("midbus_cmd_ready", 32'(link.cmd_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(link.cmd_ready), 32'd1);
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (link.rsp_valid || link.wb_cyc_o) ok = 1'b0;
        end
        check("post_rst_silent", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        do_txn(8'h57, 8'h61, 32'h5566_7788, 0, 32'h0, 0, 1'b0);

        // Randomized commands, ack delays and response backpressure
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                op = 8'h57;
            end else if (r == 1) begin
                op = 8'h52;
            end else begin
                op = 8'($urandom);
                if (op == 8'h57 || op == 8'h52) op = 8'h00;
            end
            do_txn(op, 8'($urandom), $urandom, $urandom_range(0, TO + 1), $urandom,
                   $urandom_range(0, 1), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/glitchcore_wb_host.md
GLITCHCORE_WB_HOST -- requirements
Module: glitchcore_wb_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: number of cycles to wait for wb_ack_i before aborting a bus cycle (range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_data, input, 8: command byte stream from host.
REQ-005 SHALL have port cmd_valid, input, 1: cmd_data is valid.
REQ-006 SHALL have port cmd_ready, output, 1: block accepts cmd_data.
REQ-007 SHALL have port rsp_data, output, 8: response byte stream to host.
REQ-008 SHALL have port rsp_valid, output, 1: rsp_data is valid.
REQ-009 SHALL have port rsp_ready, input, 1: host accepts rsp_data.
REQ-010 SHALL have Wishbone classic initiator ports:
- wb_adr_o, output, 32
- wb_dat_o, output, 32
- wb_dat_i, input, 32
- wb_we_o, output, 1
- wb_sel_o, output, 1
- wb_stb_o, output, 1
- wb_cyc_o, output, 1
- wb_ack_i, input, 1

Function
REQ-011 SHALL transfer a stream byte only on a clock edge where both valid and ready are high.
REQ-012 SHALL implement the states IDLE, ADDR, DATA, BUS and RESP.
- cmd_ready is 1 in IDLE, ADDR and DATA.
- cmd_ready is 0 in BUS and RESP.
REQ-013 IDLE: accepted byte 0x57 ('W') selects a write and 0x52 ('R') selects a read, and the next state is ADDR.
REQ-014 IDLE: any other accepted byte SHALL queue a single response byte 0xFF and go to RESP; no bus cycle is issued.
REQ-015 ADDR: the accepted byte is latched as the address and the next state is DATA for a write or BUS for a read.
REQ-016 DATA: SHALL accept exactly 4 bytes, most significant byte first, into a 32-bit write register, then go to BUS; a 2-bit byte counter SHALL clear on entry.
REQ-017 BUS, issued on the first cycle in BUS:
- wb_cyc_o = wb_stb_o = wb_sel_o = 1.
- wb_adr_o = {24'h0, address}.
- wb_we_o = 1 for a write, 0 for a read.
- wb_dat_o = write register.
REQ-018 BUS: all Wishbone outputs SHALL hold stable until ack or timeout.
REQ-019 BUS: on the edge sampling wb_ack_i = 1, the block SHALL:
- deassert cyc/stb/sel/we the next cycle;
- latch wb_dat_i for a read;
- set status 0x00.
REQ-020 BUS timeout:
- An 8-bit wait counter SHALL clear on entry to BUS and increment each cycle without ack.
- When the counter reaches TIMEOUT with no ack, the block SHALL drop the cycle and set status 0xEE.
- On a read timeout, the read data SHALL be 0x00000000.
REQ-021 SHALL never assert wb_cyc_o or wb_stb_o outside BUS; ack arriving outside BUS SHALL be ignored.
REQ-022 RESP, write: SHALL emit 1 byte, the status.
REQ-023 RESP, read: SHALL emit 5 bytes, the status followed by the read data MSB first.
REQ-024 RESP: rsp_valid = 1 throughout; rsp_data SHALL hold stable while rsp_ready = 0.
REQ-025 SHALL return to IDLE on the edge the last response byte is accepted; a back-to-back command byte may be accepted on the next cycle.
REQ-026 Ack and timeout terminal count on the same edge: ack SHALL win (status 0x00).
REQ-027 Latency: with cmd_valid always high and ack in the first BUS cycle, the first response byte SHALL become valid 2 cycles after the last command byte is accepted.

Reset
REQ-028 While rst = 0, the block SHALL asynchronously force state IDLE and all counters and registers to 0.
REQ-029 Output values while rst = 0:
- cmd_ready = 0.
- rsp_valid = 0, rsp_data = 0x00.
- wb_cyc_o = wb_stb_o = wb_we_o = wb_sel_o = 0.
- wb_adr_o = wb_dat_o = 0.
REQ-030 Reset asserted mid-BUS or mid-RESP SHALL abort the transaction immediately with no response emitted; cmd_ready = 1 on the first edge after rst returns high.

Verification
REQ-031 Write: bytes 57,14,00,00,00,08; ack 1 cycle after stb -> exactly one cycle of cyc/stb with adr 0x14, dat 0x00000008, we = 1; response 0x00.
REQ-032 Read: bytes 52,24; slave acks with wb_dat_i = 0x00000010 -> we = 0; responses 00,00,00,00,10 in order.
REQ-033 Timeout: TIMEOUT = 4, slave never acks; write to 0x30 -> cyc/stb high exactly 4 cycles then low; response 0xEE.
REQ-034 Bad opcode: byte 0x41 -> response 0xFF; wb_cyc_o stays 0; next command processed normally.
REQ-035 Backpressure: rsp_ready held 0 for 3 cycles during a read response -> rsp_data/rsp_valid stable; all 5 bytes delivered once, none duplicated.
REQ-036 Reset during BUS (rst = 0 while wb_stb_o = 1) -> cyc/stb drop without a clock edge; no response emitted; a subsequent write completes normally.
